// File: rtl/credit_vc_rx_buffer.sv
// credit_vc_rx_buffer: per-VC show-ahead flit FIFOs with one credit per pop.
// Define CREDIT_RX_REG_GNT_EN to drive o_vc_credit_gnt from a flop.
module credit_vc_rx_buffer #(
  parameter int VC_W   = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flit_valid,
  input  logic [VC_W-1:0]                     i_flit_vc,
  input  logic [DATA_W-1:0]                   i_flit_data,
  output logic [VC_W-1:0]                     o_vc_credit_gnt,
  output logic [VC_W-1:0]                     o_vc_valid,
  output logic [VC_W-1:0][DATA_W-1:0]         o_vc_data,
  input  logic [VC_W-1:0]                     i_vc_ready,
  output logic [VC_W-1:0][$clog2(DEPTH)-1:0]  o_occupancy,
  output logic                                o_overflow
);

  localparam int CW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH-1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH-1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-2);

  logic [VC_W-1:0][CW-1:0] cnt;
  logic [VC_W-1:0][PW-1:0] wr_ptr;
  logic [VC_W-1:0][PW-1:0] rd_ptr;
  logic [DATA_W-1:0]       mem [VC_W][DEPTH-1];

  logic            flit_ok;
  logic            drop;
  logic [VC_W-1:0] hit;
  logic [VC_W-1:0] full;
  logic [VC_W-1:0] push;
  logic [VC_W-1:0] pop;

  // Pointers wrap explicitly so DEPTH-1 need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // A malformed VC select writes nothing.
  assign flit_ok = i_flit_valid & $onehot(i_flit_vc);

  // Per-VC push/pop decode and show-ahead head outputs.
  always_comb begin
    drop        = 1'b0;
    hit         = '0;
    full        = '0;
    push        = '0;
    pop         = '0;
    o_vc_valid  = '0;
    o_vc_data   = '0;
    o_occupancy = '0;
    for (int v = 0; v < VC_W; v++) begin
      full[v]        = (cnt[v] == FULL);
      hit[v]         = flit_ok & i_flit_vc[v];
      push[v]        = hit[v] & ~full[v];
      o_vc_valid[v]  = (cnt[v] != '0);
      pop[v]         = o_vc_valid[v] & i_vc_ready[v];
      drop           = drop | (hit[v] & full[v]);
      o_vc_data[v]   = mem[v][rd_ptr[v]];
      o_occupancy[v] = cnt[v];
    end
  end

  // Counts, pointers and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (drop) o_overflow <= 1'b1;
      for (int v = 0; v < VC_W; v++) begin
        if (push[v]) wr_ptr[v] <= bump(wr_ptr[v]);
        if (pop[v])  rd_ptr[v] <= bump(rd_ptr[v]);
        unique case ({push[v], pop[v]})
          2'b10:   cnt[v] <= cnt[v] + 1'b1;
          2'b01:   cnt[v] <= cnt[v] - 1'b1;
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  // Flit storage, not reset.
  always_ff @(posedge i_clk) begin
    for (int v = 0; v < VC_W; v++)
      if (push[v]) mem[v][wr_ptr[v]] <= i_flit_data;
  end

`ifdef CREDIT_RX_REG_GNT_EN
  // Credit returned one cycle after the pop to cut the consumer->TX path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_vc_credit_gnt <= '0;
    else          o_vc_credit_gnt <= pop;
  end
`else
  assign o_vc_credit_gnt = pop;
`endif

  a_vc_onehot: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    i_flit_valid |-> $onehot(i_flit_vc));

endmodule

// File: tb/tb_credit_vc_rx_buffer.sv
// tb_credit_vc_rx_buffer: queue-model check of credit_vc_rx_buffer.
// Directed fill/drain/wrap cases plus random credit loopback traffic.
module tb_credit_vc_rx_buffer;

  localparam int VC_W  = 2;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH);

  logic                         i_clk = 1'b0;
  logic                         i_rst_n = 1'b1;
  logic                         i_flit_valid = 1'b0;
  logic [VC_W-1:0]              i_flit_vc = '0;
  logic [DW-1:0]                i_flit_data = '0;
  logic [VC_W-1:0]              o_vc_credit_gnt;
  logic [VC_W-1:0]              o_vc_valid;
  logic [VC_W-1:0][DW-1:0]      o_vc_data;
  logic [VC_W-1:0]              i_vc_ready = '0;
  logic [VC_W-1:0][CW-1:0]      o_occupancy;
  logic                         o_overflow;

  credit_vc_rx_buffer #(.VC_W(VC_W), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_flit_valid    (i_flit_valid),
    .i_flit_vc       (i_flit_vc),
    .i_flit_data     (i_flit_data),
    .o_vc_credit_gnt (o_vc_credit_gnt),
    .o_vc_valid      (o_vc_valid),
    .o_vc_data       (o_vc_data),
    .i_vc_ready      (i_vc_ready),
    .o_occupancy     (o_occupancy),
    .o_overflow      (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per VC plus sticky overflow.
  logic [DW-1:0]   q [VC_W][$];
  logic            m_ovf = 1'b0;
  logic [VC_W-1:0] m_gnt_r = '0;

  // TX side of the credit loop.
  int              cred [VC_W];
  logic            loop_en = 1'b0;
  logic [VC_W-1:0] gnt_neg = '0;
  int              gnt0_cnt = 0;

  task automatic chk(input string name, input int v,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vc%0d: got %0h expected %0h @%0t",
               name, v, act, exp, $time);
    end
  endtask

  // Model update on the active edge, from the inputs the DUT samples.
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int v = 0; v < VC_W; v++) q[v].delete();
      m_ovf   = 1'b0;
      m_gnt_r = '0;
    end else begin
      for (int v = 0; v < VC_W; v++) begin
        bit pop_v, wr_v, full_v;
        pop_v  = (q[v].size() > 0) && i_vc_ready[v];
        full_v = (q[v].size() == DEPTH-1);
        wr_v   = i_flit_valid && $onehot(i_flit_vc) && i_flit_vc[v];
        if (wr_v && full_v) m_ovf = 1'b1;
        if (pop_v) void'(q[v].pop_front());
        if (wr_v && !full_v) q[v].push_back(i_flit_data);
        m_gnt_r[v] = pop_v;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge i_clk) begin
    gnt_neg = o_vc_credit_gnt;
    if (o_vc_credit_gnt[0]) gnt0_cnt++;
    if (!i_rst_n) begin
      chk("rst_valid", 0, 32'(o_vc_valid), 0);
      chk("rst_gnt", 0, 32'(o_vc_credit_gnt), 0);
      chk("rst_ovf", 0, 32'(o_overflow), 0);
      for (int v = 0; v < VC_W; v++)
        chk("rst_occ", v, 32'(o_occupancy[v]), 0);
    end else begin
      chk("overflow", 0, 32'(o_overflow), 32'(m_ovf));
      for (int v = 0; v < VC_W; v++) begin
        int sz;
        bit eg;
        sz = q[v].size();
`ifdef CREDIT_RX_REG_GNT_EN
        eg = m_gnt_r[v];
`else
        eg = (sz > 0) && i_vc_ready[v];
`endif
        chk("valid", v, 32'(o_vc_valid[v]), 32'(sz > 0));
        chk("occupancy", v, 32'(o_occupancy[v]), 32'(sz));
        chk("gnt", v, 32'(o_vc_credit_gnt[v]), 32'(eg));
        if (sz > 0) chk("data", v, o_vc_data[v], q[v][0]);
        if (loop_en) begin
          int tot;
          tot = sz + cred[v] + int'(i_flit_valid && i_flit_vc[v]);
`ifdef CREDIT_RX_REG_GNT_EN
          tot += int'(eg);
`endif
          chk("credit_invariant", v, tot, DEPTH-1);
        end
      end
    end
  end

  task automatic drive(input bit fv, input logic [VC_W-1:0] vc,
                       input logic [DW-1:0] d, input logic [VC_W-1:0] rdy);
    i_flit_valid = fv;
    i_flit_vc    = vc;
    i_flit_data  = d;
    i_vc_ready   = rdy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle(1);

    // Fill VC0 with 1..7, then an 8th flit must be dropped.
    for (int i = 1; i <= 7; i++) drive(1'b1, 2'b01, DW'(i), 2'b00);
    chk("fill_occ", 0, 32'(o_occupancy[0]), 7);
    chk("fill_ovf", 0, 32'(o_overflow), 0);
    drive(1'b1, 2'b01, 32'h8, 2'b00);
    chk("full_occ", 0, 32'(o_occupancy[0]), 7);
    chk("full_ovf", 0, 32'(o_overflow), 1);
    chk("full_head", 0, o_vc_data[0], 32'h1);
    idle(2);
    chk("ovf_sticky", 0, 32'(o_overflow), 1);

    // Drain VC0 in order; exactly 7 credits.
    gnt0_cnt = 0;
    for (int i = 0; i < 7; i++) drive(1'b0, '0, '0, 2'b01);
    chk("drain_valid", 0, 32'(o_vc_valid[0]), 0);
    idle(2);
    chk("drain_gnt_cnt", 0, gnt0_cnt, 7);

    // Wrap: VC1 held at 3 while 20 push/pop pairs cross the pointer wrap.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b10, 32'h100 + DW'(i), 2'b00);
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b10, 32'h200 + DW'(i), 2'b10);
    chk("wrap_occ", 1, 32'(o_occupancy[1]), 3);
    chk("wrap_head", 1, o_vc_data[1], 32'h211);

    // Push VC0 while popping VC1, then drain VC1 and push into empty VC1
    // with ready high: no pop of the new flit.
    drive(1'b1, 2'b01, 32'h55, 2'b10);
    chk("cross_occ0", 0, 32'(o_occupancy[0]), 1);
    chk("cross_occ1", 1, 32'(o_occupancy[1]), 2);
    drive(1'b0, '0, '0, 2'b11);
    drive(1'b0, '0, '0, 2'b10);
    chk("empty_vc1", 1, 32'(o_vc_valid[1]), 0);
    drive(1'b1, 2'b10, 32'h66, 2'b10);
    chk("nobypass_valid", 1, 32'(o_vc_valid[1]), 1);
    chk("nobypass_data", 1, o_vc_data[1], 32'h66);
    idle(1);

    // Random traffic, then reset in the middle of it.
    for (int i = 0; i < 30; i++) begin
      logic [VC_W-1:0] vc;
      vc = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      drive(1'($urandom), vc, $urandom, VC_W'($urandom));
    end
    i_rst_n = 1'b0;
    #2;
    chk("midrst_valid", 0, 32'(o_vc_valid), 0);
    chk("midrst_occ", 0, 32'(o_occupancy), 0);
    chk("midrst_ovf", 0, 32'(o_overflow), 0);
    chk("midrst_gnt", 0, 32'(o_vc_credit_gnt), 0);
    @(posedge i_clk);
    #1;
    i_flit_valid = 1'b0;
    i_vc_ready   = '0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle(2);

    // Loopback: TX spends credits, returned grants refill them.
    begin
      int sent, cyc;
      sent = 0;
      cyc  = 0;
      for (int v = 0; v < VC_W; v++) cred[v] = DEPTH-1;
      i_flit_valid = 1'b0;
      i_vc_ready   = '0;
      loop_en = 1'b1;
      while (sent < 10000 && cyc < 40000) begin
        int v;
        for (int k = 0; k < VC_W; k++) cred[k] += int'(gnt_neg[k]);
        v = $urandom_range(0, VC_W-1);
        i_flit_valid = 1'b0;
        i_flit_vc    = '0;
        if (cred[v] > 0 && $urandom_range(0, 3) != 0) begin
          i_flit_valid = 1'b1;
          i_flit_vc    = VC_W'(1) << v;
          i_flit_data  = $urandom;
          cred[v]--;
          sent++;
        end
        i_vc_ready = VC_W'($urandom);
        @(posedge i_clk);
        #1;
        cyc++;
      end
      chk("loop_sent", 0, sent, 10000);
      for (int i = 0; i < 20; i++) begin
        for (int k = 0; k < VC_W; k++) cred[k] += int'(gnt_neg[k]);
        i_flit_valid = 1'b0;
        i_flit_vc    = '0;
        i_vc_ready   = '1;
        @(posedge i_clk);
        #1;
      end
      loop_en = 1'b0;
      chk("loop_ovf", 0, 32'(o_overflow), 0);
      for (int k = 0; k < VC_W; k++) begin
        chk("loop_occ", k, 32'(o_occupancy[k]), 0);
        chk("loop_cred", k, cred[k], DEPTH-1);
      end
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
